// File: rtl/pipe_pkg.sv
// Shared pipeline-register constants and the skid-stage state type.
// Used by pipe_stage_skid and its helpers.
package pipe_pkg;

  localparam int IFID_W = 128;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_BUSY  = OCC_BUSY,
    ST_FULL  = OCC_FULL
  } skid_st_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used by the optional perf counters of pipe_stage_skid.
module pipe_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a two-entry skid buffer and flush.
// Optional stall/bubble counters under `PIPE_STAGE_PERF_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = IFID_W,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  skid_st_e st_q;
  skid_st_e st_d;

  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              rdy_q;

  logic main_v;
  logic skid_v;
  logic acc;
  logic emit;
  logic ld_main;
  logic ld_skid;
  logic from_skid;

  assign main_v = (st_q != ST_EMPTY);
  assign skid_v = (st_q == ST_FULL);
  assign acc    = in_valid & rdy_q;
  assign emit   = main_v & out_ready;

  assign in_ready  = rdy_q;
  assign out_valid = main_v;
  assign out_data  = main_q;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  always_comb begin
    st_d      = st_q;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    unique case (st_q)
      ST_EMPTY: begin
        if (acc) begin
          st_d    = ST_BUSY;
          ld_main = 1'b1;
        end
      end
      ST_BUSY: begin
        unique case (1'b1)
          acc & emit: begin
            ld_main = 1'b1;
          end
          acc & !emit: begin
            st_d    = ST_FULL;
            ld_skid = 1'b1;
          end
          !acc & emit: begin
            st_d = ST_EMPTY;
          end
          !acc & !emit: begin
            st_d = ST_BUSY;
          end
        endcase
      end
      ST_FULL: begin
        if (emit) begin
          st_d      = ST_BUSY;
          ld_main   = 1'b1;
          from_skid = 1'b1;
        end
      end
      default: begin
        st_d = ST_EMPTY;
      end
    endcase
    // a redirect drops both entries and any handshake this cycle
    if (flush) begin
      st_d      = ST_EMPTY;
      ld_main   = 1'b0;
      ld_skid   = 1'b0;
      from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_EMPTY;
      rdy_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      rdy_q <= (st_d != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_q <= RESET_DATA;
      skid_q <= RESET_DATA;
    end else begin
      if (ld_main) begin
        main_q <= from_skid ? skid_q : in_data;
      end
      if (ld_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = main_v & !out_ready;
  assign bubble_inc = !main_v & !rst;

  pipe_sat_counter #(
    .W (32)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(
    .W (32)
  ) u_bubble_cnt (
    .clk (clk),
    .clr (rst),
    .inc (bubble_inc),
    .cnt (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, backpressure,
// flush, reset, ready toggling and (optionally) perf counters.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam logic [DW-1:0] RD = 16'hDEAD;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  int nvec;
  int nerr;

  pipe_stage_skid #(
    .DATA_W     (DW),
    .RESET_DATA (RD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush      (flush),
    .occupancy  (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d;
  logic [DW-1:0] held;
  logic          hold_chk;
  int            m_occ;
  logic          m_rdy;
  logic          m_acc;
  logic          m_emit;
  int            k;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   s0;
  logic [31:0]   b0;
`endif

  initial begin
    nvec      = 0;
    nerr      = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // reset state
    tick();
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_irdy", 32'(in_ready), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_data", 32'(out_data), 32'(RD));
    rst = 1'b0;
    tick();
    chk("post_rst_irdy", 32'(in_ready), 32'd1);
    chk("post_rst_ovalid", 32'(out_valid), 32'd0);

    // streaming
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = DW'(i);
      tick();
      chk("strm_data", 32'(out_data), 32'(i));
      chk("strm_ovalid", 32'(out_valid), 32'd1);
      chk("strm_irdy", 32'(in_ready), 32'd1);
      chk("strm_occ", 32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("strm_end_ovalid", 32'(out_valid), 32'd0);
    chk("strm_end_occ", 32'(occupancy), 32'd0);

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    tick();
    chk("bp_a_data", 32'(out_data), 32'h000A);
    chk("bp_a_irdy", 32'(in_ready), 32'd1);
    in_data = 16'h000B;
    tick();
    chk("bp_b_irdy", 32'(in_ready), 32'd0);
    chk("bp_b_occ", 32'(occupancy), 32'd2);
    chk("bp_b_data", 32'(out_data), 32'h000A);
    in_data = 16'h000C;
    tick();
    chk("bp_c_data", 32'(out_data), 32'h000A);
    chk("bp_c_occ", 32'(occupancy), 32'd2);
    chk("bp_c_irdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", 32'(out_data), 32'h000B);
    chk("bp_out_b_occ", 32'(occupancy), 32'd1);
    chk("bp_out_b_irdy", 32'(in_ready), 32'd1);
    tick();
    chk("bp_out_c", 32'(out_data), 32'h000C);
    chk("bp_out_c_v", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_v", 32'(out_valid), 32'd0);

    // flush while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    chk("fl_pre_occ", 32'(occupancy), 32'd2);
    in_data = 16'h00DD;
    flush   = 1'b1;
    chk("fl_cycle_irdy", 32'(in_ready), 32'd0);
    chk("fl_cycle_ov", 32'(out_valid), 32'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_ovalid", 32'(out_valid), 32'd0);
    chk("fl_occ", 32'(occupancy), 32'd0);
    chk("fl_data", 32'(out_data), 32'(RD));
    chk("fl_irdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_no_d_1", 32'(out_valid), 32'd0);
    tick();
    chk("fl_no_d_2", 32'(out_valid), 32'd0);

    // reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0031;
    tick();
    in_data = 16'h0032;
    tick();
    chk("mr_pre_occ", 32'(occupancy), 32'd2);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mr_ovalid", 32'(out_valid), 32'd0);
    chk("mr_irdy", 32'(in_ready), 32'd0);
    chk("mr_occ", 32'(occupancy), 32'd0);
    chk("mr_data", 32'(out_data), 32'(RD));
    out_ready = 1'b1;
    tick();
    chk("mr_irdy2", 32'(in_ready), 32'd1);
    chk("mr_ovalid2", 32'(out_valid), 32'd0);

    // ready toggling against a queue model
    m_occ    = 0;
    m_rdy    = 1'b1;
    k        = 0;
    hold_chk = 1'b0;
    held     = '0;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c % 2 == 0);
      in_data   = DW'(16'h0100 + k);
      if (hold_chk) begin
        chk("tg_stable", 32'(out_data), 32'(held));
      end
      chk("tg_irdy", 32'(in_ready), 32'(m_rdy));
      chk("tg_ov", 32'(out_valid), 32'(m_occ > 0));
      m_acc  = m_rdy;
      m_emit = out_ready && (m_occ > 0);
      if (m_emit) begin
        exp_d = q.pop_front();
        chk("tg_order", 32'(out_data), 32'(exp_d));
      end
      hold_chk = (m_occ > 0) && !out_ready;
      held     = out_data;
      if (m_acc) begin
        q.push_back(in_data);
        k++;
      end
      m_occ = m_occ + int'(m_acc) - int'(m_emit);
      m_rdy = (m_occ < 2);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (q.size() > 0 && out_valid) begin
        exp_d = q.pop_front();
        chk("tg_drain", 32'(out_data), 32'(exp_d));
      end
      tick();
    end
    chk("tg_q_empty", 32'(q.size()), 32'd0);
    chk("tg_end_ov", 32'(out_valid), 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0055;
    tick();
    in_valid = 1'b0;
    chk("pf_ov", 32'(out_valid), 32'd1);
    s0 = stall_cnt;
    repeat (5) tick();
    chk("pf_stall", stall_cnt - s0, 32'd5);
    out_ready = 1'b1;
    tick();
    b0 = bubble_cnt;
    repeat (3) tick();
    chk("pf_bubble", bubble_cnt - b0, 32'd3);
    chk("pf_stall_hold", stall_cnt - s0, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
